// File: rtl/fr_pe_dispatcher.sv
//------------------------------------------------------------------------------
// Module      : fr_pe_dispatcher
// Description : Initiator for fr_processing_element. Gathers a NUM_TAPS sample
//               window from a valid/ready stream, then for every fuzzy rule
//               fetches the mean/variance vectors, starts the PE, waits for
//               its ready pulse (with timeout) and emits a tagged result.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fr_pe_dispatcher #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 32,
  parameter int NUM_RULES  = 8,
  parameter int RULE_AW    = 3,
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  // sample stream
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  // parameter memory
  output logic                           param_rd,
  output logic [RULE_AW-1:0]             param_addr,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0] param_m,
  input  logic [NUM_TAPS*DATA_WIDTH-1:0] param_v,
  // processing element
  output logic                           pe_start,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] pe_x,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] pe_m,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] pe_v,
  input  logic                           pe_ready,
  input  logic [DATA_WIDTH-1:0]          pe_pixel,
  // result stream
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [DATA_WIDTH-1:0]          res_data,
  output logic [RULE_AW-1:0]             res_rule,
  output logic                           res_last,
  output logic                           res_err
);

  localparam int CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [CNT_W-1:0]   LAST_TAP  = CNT_W'(NUM_TAPS - 1);
  localparam logic [RULE_AW-1:0] LAST_RULE = RULE_AW'(NUM_RULES - 1);
  localparam logic [TMR_W-1:0]   TMR_MAX   = TMR_W'(TIMEOUT);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_FETCH   = 3'd1,
    ST_PWAIT   = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_BUSY    = 3'd4,
    ST_EMIT    = 3'd5,
    ST_GAP     = 3'd6
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [RULE_AW-1:0] rule;
  logic [TMR_W-1:0]   timer;
  logic [GAP_W-1:0]   gap_cnt;
  logic [TMR_W-1:0]   timer_next;

  // Timer advances once per BUSY cycle and holds at TIMEOUT instead of wrapping.
  always_comb begin
    timer_next = (timer == TMR_MAX) ? timer : timer + TMR_W'(1);
  end

  // Dispatcher sequencer: window capture, per-rule fetch/issue/wait/emit loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_COLLECT;
      cnt        <= '0;
      rule       <= '0;
      timer      <= '0;
      gap_cnt    <= '0;
      s_ready    <= 1'b0;
      param_rd   <= 1'b0;
      param_addr <= '0;
      pe_start   <= 1'b0;
      pe_x       <= '0;
      pe_m       <= '0;
      pe_v       <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_rule   <= '0;
      res_last   <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed by a transition below.
      param_rd <= 1'b0;
      pe_start <= 1'b0;

      case (state)
        ST_COLLECT: begin
          if (!s_ready) begin
            // First cycle out of reset: open the input port.
            s_ready <= 1'b1;
          end else if (s_valid) begin
            pe_x[cnt*DATA_WIDTH +: DATA_WIDTH] <= s_data;
            if (cnt == LAST_TAP) begin
              cnt        <= '0;
              s_ready    <= 1'b0;
              rule       <= '0;
              param_rd   <= 1'b1;
              param_addr <= '0;
              state      <= ST_FETCH;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        ST_FETCH: begin
          // Read strobe is active this cycle; data arrives during PWAIT.
          state <= ST_PWAIT;
        end

        ST_PWAIT: begin
          pe_m     <= param_m;
          pe_v     <= param_v;
          pe_start <= 1'b1;
          timer    <= '0;
          state    <= ST_ISSUE;
        end

        ST_ISSUE: begin
          state <= ST_BUSY;
        end

        ST_BUSY: begin
          timer <= timer_next;
          // A ready arriving on the expiry cycle still counts as a real answer.
          if (pe_ready) begin
            res_data  <= pe_pixel;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            res_rule  <= rule;
            res_last  <= (rule == LAST_RULE);
            state     <= ST_EMIT;
          end else if (timer_next == TMR_MAX) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            res_rule  <= rule;
            res_last  <= (rule == LAST_RULE);
            state     <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end
        end

        ST_GAP: begin
          // Give the PE time to drop back to idle before the next start.
          if (gap_cnt == GAP_LAST) begin
            if (rule == LAST_RULE) begin
              cnt     <= '0;
              s_ready <= 1'b1;
              state   <= ST_COLLECT;
            end else begin
              rule       <= rule + RULE_AW'(1);
              param_rd   <= 1'b1;
              param_addr <= rule + RULE_AW'(1);
              state      <= ST_FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fr_pe_dispatcher.sv
//------------------------------------------------------------------------------
// Module      : tb_fr_pe_dispatcher
// Description : Self-checking bench for fr_pe_dispatcher with a parameter
//               memory model, a PE model and a result scoreboard.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fr_pe_dispatcher;

  localparam int DW    = 16;
  localparam int TAPS  = 32;
  localparam int RULES = 2;
  localparam int RAW   = 3;
  localparam int TMO   = 64;
  localparam int GAP   = 2;
  localparam int VW    = TAPS * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic            param_rd;
  logic [RAW-1:0]  param_addr;
  logic [VW-1:0]   param_m;
  logic [VW-1:0]   param_v;
  logic            pe_start;
  logic [VW-1:0]   pe_x;
  logic [VW-1:0]   pe_m;
  logic [VW-1:0]   pe_v;
  logic            pe_ready;
  logic [DW-1:0]   pe_pixel;
  logic            res_valid;
  logic            res_ready;
  logic [DW-1:0]   res_data;
  logic [RAW-1:0]  res_rule;
  logic            res_last;
  logic            res_err;

  fr_pe_dispatcher #(
    .DATA_WIDTH(DW), .NUM_TAPS(TAPS), .NUM_RULES(RULES), .RULE_AW(RAW),
    .TIMEOUT(TMO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .param_rd(param_rd), .param_addr(param_addr), .param_m(param_m), .param_v(param_v),
    .pe_start(pe_start), .pe_x(pe_x), .pe_m(pe_m), .pe_v(pe_v),
    .pe_ready(pe_ready), .pe_pixel(pe_pixel),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rule(res_rule), .res_last(res_last), .res_err(res_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0]  data;
    logic [RAW-1:0] rule;
    logic           last;
    logic           err;
  } exp_t;

  exp_t    sb[$];
  int      exp_rule_q[$];
  int      start_q[$];
  int      rv_q[$];
  int      addr_q[$];
  logic [DW-1:0] win_exp [TAPS];

  int checks = 0;
  int errors = 0;
  int pe_lat = 13;
  bit win_busy = 1'b0;
  bit sready_viol = 1'b0;
  int first_acc, last_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=expired expected=event (t=%0t)", name, $time);
  endtask

  function automatic logic [DW-1:0] m_lane(input int r, input int i);
    return DW'(r * 256 + i * 3 + 7);
  endfunction

  function automatic logic [DW-1:0] v_lane(input int r, input int i);
    return DW'(r * 512 + i + 1000);
  endfunction

  function automatic logic [DW-1:0] exp_pixel(input int r);
    return m_lane(r, 0) ^ 16'hA5A5;
  endfunction

  // Parameter memory: data valid only in the cycle after the read strobe.
  initial begin
    bit rd_d = 1'b0;
    int addr_d = 0;
    param_m = '0;
    param_v = '0;
    forever begin
      @(negedge clk);
      if (rd_d) begin
        for (int i = 0; i < TAPS; i++) begin
          param_m[i*DW +: DW] = m_lane(addr_d, i);
          param_v[i*DW +: DW] = v_lane(addr_d, i);
        end
      end else begin
        param_m = {TAPS{16'hBEEF}};
        param_v = {TAPS{16'hDEAD}};
      end
      rd_d = param_rd;
      addr_d = int'(param_addr);
      if (param_rd) addr_q.push_back(int'(param_addr));
    end
  end

  // PE model: answers pe_lat cycles after start (never when pe_lat <= 0).
  initial begin
    bit pending = 1'b0;
    int ready_at = 0;
    logic [VW-1:0] x_snap, m_snap, v_snap;
    pe_ready = 1'b0;
    pe_pixel = '0;
    forever begin
      @(negedge clk);
      #1;
      pe_ready = 1'b0;
      pe_pixel = 16'hDEAD;
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (pending && cyc == ready_at) begin
          check("pe_inputs_stable", (pe_x === x_snap && pe_m === m_snap && pe_v === v_snap), 1);
          pe_ready = 1'b1;
          pe_pixel = pe_m[DW-1:0] ^ 16'hA5A5;
          pending = 1'b0;
        end
        if (pe_start) begin
          int bad = 0;
          int r;
          start_q.push_back(cyc);
          x_snap = pe_x; m_snap = pe_m; v_snap = pe_v;
          if (exp_rule_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pe_start unexpected actual=start expected=none (t=%0t)", $time);
          end else begin
            r = exp_rule_q.pop_front();
            for (int i = 0; i < TAPS; i++) begin
              if (pe_x[i*DW +: DW] !== win_exp[i]) bad++;
              if (pe_m[i*DW +: DW] !== m_lane(r, i)) bad++;
              if (pe_v[i*DW +: DW] !== v_lane(r, i)) bad++;
            end
            check("pe_lanes_bad_count", bad, 0);
          end
          if (pe_lat > 0) begin
            pending = 1'b1;
            ready_at = cyc + pe_lat;
          end
        end
      end
    end
  end

  // Result monitor: pops the scoreboard on every result handshake.
  initial begin
    bit prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (win_busy && s_ready) sready_viol = 1'b1;
      if (res_valid && !prev_rv) rv_q.push_back(cyc);
      prev_rv = res_valid;
      if (!rst && res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_unexpected actual=%0h expected=none", res_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_data", res_data, e.data);
          check("res_rule", res_rule, e.rule);
          check("res_last", res_last, e.last);
          check("res_err",  res_err,  e.err);
          if (e.last) win_busy = 1'b0;
        end
      end
    end
  end

  task automatic expect_window(input bit timeout);
    for (int r = 0; r < RULES; r++) begin
      exp_t e;
      e.data = timeout ? '0 : exp_pixel(r);
      e.rule = RAW'(r);
      e.last = (r == RULES - 1);
      e.err  = timeout;
      sb.push_back(e);
      exp_rule_q.push_back(r);
    end
  endtask

  task automatic send_range(input int first, input int count, input int base, input bit toggle);
    for (int k = 0; k < count; k++) begin
      int guard = 0;
      s_valid = 1'b1;
      s_data  = DW'(base + first + k);
      win_exp[first + k] = DW'(base + first + k);
      while (!s_ready && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      if (!s_ready) begin
        fail_timeout("s_accept");
        s_valid = 1'b0;
        return;
      end
      if (k == 0) first_acc = cyc;
      last_acc = cyc;
      @(negedge clk);
      if (toggle) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((sb.size() != 0 || win_busy || !s_ready) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) fail_timeout("wait_idle");
  endtask

  task automatic clear_logs();
    start_q.delete(); rv_q.delete(); addr_q.delete();
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {s_ready, param_rd, pe_start, res_valid, res_err, res_last}, 6'b0);
    check("rst_pe_x", (pe_x == '0), 1);
    rst = 1'b0;
    @(negedge clk);
    check("s_ready_after_rst", s_ready, 1);

    // 1) back-to-back window 0..31, L=13
    clear_logs(); pe_lat = 13;
    expect_window(1'b0);
    send_range(0, TAPS, 0, 1'b0);
    win_busy = 1'b1;
    wait_idle();
    check("t1_starts", start_q.size(), 2);
    check("t1_addrs", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      check("t1_addr0", addr_q[0], 0);
      check("t1_addr1", addr_q[1], 1);
    end
    if (start_q.size() == 2 && rv_q.size() >= 1) begin
      check("t1_first_start", start_q[0] - last_acc, 3);
      check("t1_first_result", rv_q[0] - last_acc, 3 + 13 + 1);
      check("t1_rule_period", start_q[1] - start_q[0], 13 + 4 + GAP);
    end

    // 2) s_valid toggling, same window contents
    clear_logs(); sready_viol = 1'b0;
    expect_window(1'b0);
    send_range(0, TAPS, 0, 1'b1);
    win_busy = 1'b1;
    check("t2_window_span", last_acc - first_acc + 1, 63);
    wait_idle();
    check("t2_s_ready_low_while_busy", sready_viol, 0);

    // 3) res_ready held low in EMIT for 10 cycles
    begin
      bit viol = 1'b0;
      int guard = 0;
      logic [DW-1:0] d;
      logic [RAW-1:0] r;
      clear_logs();
      res_ready = 1'b0;
      expect_window(1'b0);
      send_range(0, TAPS, 16'hFFF0, 1'b0);
      win_busy = 1'b1;
      while (!res_valid && guard < 200) begin @(negedge clk); guard++; end
      if (!res_valid) fail_timeout("t3_res_valid");
      d = res_data; r = res_rule;
      repeat (10) begin
        @(negedge clk);
        if (!res_valid || res_data !== d || res_rule !== r || param_rd || pe_start) viol = 1'b1;
      end
      check("t3_hold_stable", viol, 0);
      res_ready = 1'b1;
      wait_idle();
      check("t3_starts", start_q.size(), 2);
    end

    // 4) PE never answers -> timeout results
    clear_logs(); pe_lat = 0;
    expect_window(1'b1);
    send_range(0, TAPS, 100, 1'b0);
    win_busy = 1'b1;
    wait_idle();
    check("t4_starts", start_q.size(), 2);
    if (start_q.size() >= 1 && rv_q.size() >= 1)
      check("t4_timeout_latency", rv_q[0] - start_q[0], TMO + 1);

    // 5) ready on exactly the 64th BUSY cycle -> real answer wins
    clear_logs(); pe_lat = TMO;
    expect_window(1'b0);
    send_range(0, TAPS, 200, 1'b0);
    win_busy = 1'b1;
    wait_idle();
    if (start_q.size() >= 1 && rv_q.size() >= 1)
      check("t5_edge_latency", rv_q[0] - start_q[0], TMO + 1);

    // 6) reset while BUSY
    begin
      int guard = 0;
      clear_logs(); pe_lat = 0;
      expect_window(1'b0);
      send_range(0, TAPS, 300, 1'b0);
      win_busy = 1'b1;
      while (start_q.size() == 0 && guard < 100) begin @(negedge clk); guard++; end
      if (start_q.size() == 0) fail_timeout("t6_start");
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_drop", {pe_start, res_valid, s_ready}, 3'b0);
      rst = 1'b0;
      sb.delete(); exp_rule_q.delete(); win_busy = 1'b0;
      clear_logs(); pe_lat = 13;
      send_range(0, TAPS - 1, 400, 1'b0);
      repeat (20) @(negedge clk);
      check("t6_no_start_partial", start_q.size(), 0);
      expect_window(1'b0);
      send_range(TAPS - 1, 1, 400, 1'b0);
      win_busy = 1'b1;
      wait_idle();
      check("t6_starts_after", start_q.size(), 2);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
